counter_event_logger: RTL and testbench

- Downstream consumer of the counter host stage.
- Samples the host's count output each time a periodic pulse fires and tags the sample with a sticky overflow flag.
- Buffers samples in a small FIFO and drains them through a valid/ready read port.
- Keeps saturating statistics: total qualified pulses and dropped samples.

---
 rtl/counter_event_logger.sv | 121 ++++++++++++
 tb/tb_counter_event_logger.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_event_logger.sv
// Captures the host count on each qualified pulse into a small FIFO, tagged with a sticky overflow flag.
// Optional LOGGER_HIGH_WATER_EN adds a registered high_water output (peak occupancy since reset/clear).
module counter_event_logger #(
  parameter int unsigned COUNT_WIDTH = 12,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        en_in,
  input  logic [COUNT_WIDTH-1:0]      count_in,
  input  logic                        overflow_in,
  input  logic                        pulse_in,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [COUNT_WIDTH:0]        rd_data,
  output logic [$clog2(DEPTH):0]      fifo_level,
`ifdef LOGGER_HIGH_WATER_EN
  output logic [$clog2(DEPTH):0]      high_water,
`endif
  output logic [STAT_WIDTH-1:0]       pulse_total,
  output logic [STAT_WIDTH-1:0]       drop_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned DATA_W = COUNT_WIDTH + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              ovf_sticky;

  logic              capture;
  logic              ovf_q;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] entry;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head_nxt;

  // Push/pop qualification and next head/level; clear suppresses every side effect.
  always_comb begin
    capture    = en_in & pulse_in & ~clear;
    ovf_q      = en_in & overflow_in;
    pop        = rd_valid & rd_ready & ~clear;
    push       = capture & ((state != FULL) | pop);
    drop       = capture & (state == FULL) & ~pop;
    entry      = {ovf_sticky | ovf_q, count_in};
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = fifo_level + LVL_W'(push) - LVL_W'(pop);
    head_nxt   = '0;
    if (level_nxt != '0) begin
      // A push into a FIFO that is (or is becoming) empty lands directly at the head.
      if (push && (fifo_level == LVL_W'(pop))) head_nxt = entry;
      else                                     head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Occupancy FSM with registered read-port outputs and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      ovf_sticky  <= 1'b0;
      pulse_total <= '0;
      drop_count  <= '0;
    end else if (clear) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      ovf_sticky  <= 1'b0;
      pulse_total <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        EMPTY:   if (push) state <= PARTIAL;
        PARTIAL: if (level_nxt == LVL_W'(DEPTH)) state <= FULL;
                 else if (level_nxt == '0)       state <= EMPTY;
        FULL:    if (pop && !push) state <= PARTIAL;
        default: state <= EMPTY;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      rd_valid   <= (level_nxt != '0);
      rd_data    <= head_nxt;
      if (capture)    ovf_sticky <= 1'b0;
      else if (ovf_q) ovf_sticky <= 1'b1;
      if (capture && (pulse_total != '1)) pulse_total <= pulse_total + STAT_WIDTH'(1);
      if (drop && (drop_count != '1))     drop_count  <= drop_count + STAT_WIDTH'(1);
    end
  end

`ifdef LOGGER_HIGH_WATER_EN
  // Peak occupancy, tracking the same edge as fifo_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      high_water <= '0;
    else if (clear)                  high_water <= '0;
    else if (level_nxt > high_water) high_water <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger: vector table plus hand-written full/drop, clear and reset sequences.
module tb_counter_event_logger;

  localparam int unsigned CW = 12;
  localparam int unsigned DP = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          en_in = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic          overflow_in = 1'b0;
  logic          pulse_in = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [CW:0]   rd_data;
  logic [LW-1:0] fifo_level;
  logic [SW-1:0] pulse_total;
  logic [SW-1:0] drop_count;
`ifdef LOGGER_HIGH_WATER_EN
  logic [LW-1:0] high_water;
`endif

  counter_event_logger #(.COUNT_WIDTH(CW), .DEPTH(DP), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en_in(en_in), .count_in(count_in),
    .overflow_in(overflow_in), .pulse_in(pulse_in), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .fifo_level(fifo_level),
`ifdef LOGGER_HIGH_WATER_EN
    .high_water(high_water),
`endif
    .pulse_total(pulse_total), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CW:0] d,
                         input logic [LW-1:0] l, input logic [SW-1:0] pt, input logic [SW-1:0] dc);
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(v));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(d));
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'(l));
    chk({tag, " pulse_total"}, 32'(pulse_total), 32'(pt));
    chk({tag, " drop_count"}, 32'(drop_count), 32'(dc));
  endtask

  // Drive at negedge, sample 1ns after the following rising edge.
  task automatic step(input logic cl, input logic en, input logic pu, input logic ov,
                      input logic [CW-1:0] cnt, input logic rdy);
    @(negedge clk);
    clear = cl; en_in = en; pulse_in = pu; overflow_in = ov; count_in = cnt; rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic cl; logic en; logic pu; logic ov; logic [CW-1:0] cnt; logic rdy;
    logic v; logic [CW:0] data; logic [LW-1:0] lvl; logic [SW-1:0] pt; logic [SW-1:0] dc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 13'h0000, 4'd0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h063, 1'b0, 1'b1, 13'h0063, 4'd1, 16'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 13'h0000, 4'd0, 16'd1, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0, 13'h0000, 4'd0, 16'd1, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h0A0, 1'b0, 1'b1, 13'h10A0, 4'd1, 16'd2, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h104, 1'b1, 1'b1, 13'h0104, 4'd1, 16'd3, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h200, 1'b1, 1'b1, 13'h1200, 4'd1, 16'd4, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 13'h0000, 4'd0, 16'd4, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h300, 1'b0, 1'b1, 13'h0300, 4'd1, 16'd5, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 13'h0000, 4'd0, 16'd5, 16'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h007, 1'b0, 1'b0, 13'h0000, 4'd0, 16'd5, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h011, 1'b0, 1'b1, 13'h0011, 4'd1, 16'd6, 16'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 13'h0000, 4'd0, 16'd6, 16'd0};

    // Reset held with random inputs, then released with quiet inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear = 1'($urandom); en_in = 1'($urandom); pulse_in = 1'($urandom);
      overflow_in = 1'($urandom); count_in = CW'($urandom); rd_ready = 1'($urandom);
      @(posedge clk); #1;
      chk_out("reset", 1'b0, '0, '0, '0, '0);
    end
    @(negedge clk);
    clear = 0; en_in = 0; pulse_in = 0; overflow_in = 0; count_in = '0; rd_ready = 0;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 12'h000, 0);
    chk_out("post_reset", 1'b0, '0, '0, '0, '0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].cl, tbl[i].en, tbl[i].pu, tbl[i].ov, tbl[i].cnt, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].data, tbl[i].lvl, tbl[i].pt, tbl[i].dc);
    end

    // Fill past full: counts 1..10 with no reads.
    step(1, 0, 0, 0, 12'h000, 0);
    chk_out("clear0", 1'b0, '0, '0, '0, '0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 1, 0, CW'(i), 0);
      chk_out($sformatf("fill%0d", i), 1'b1, 13'h0001, LW'((i > 8) ? 8 : i),
              SW'(i), SW'((i > 8) ? i - 8 : 0));
    end
`ifdef LOGGER_HIGH_WATER_EN
    chk("high_water_full", 32'(high_water), 32'd8);
`endif
    // Capture at full with a pop is accepted.
    step(0, 1, 1, 0, 12'h055, 1);
    chk_out("full_pushpop", 1'b1, 13'h0002, 4'd8, 16'd11, 16'd2);
    for (int k = 0; k < 8; k++) begin
      logic [CW:0] exp_d;
      exp_d = (k < 7) ? 13'(k + 2) : 13'h0055;
      chk($sformatf("drain%0d valid", k), 32'(rd_valid), 32'd1);
      chk($sformatf("drain%0d data", k), 32'(rd_data), 32'(exp_d));
      step(0, 1, 0, 0, 12'h000, 1);
    end
    chk_out("drained", 1'b0, '0, '0, 16'd11, 16'd2);

    // Clear coincident with a capture at level 5.
    step(1, 0, 0, 0, 12'h000, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 0, CW'(12'h0A0 + i), 0);
    chk_out("level5", 1'b1, 13'h00A1, 4'd5, 16'd5, 16'd0);
`ifdef LOGGER_HIGH_WATER_EN
    chk("high_water_5", 32'(high_water), 32'd5);
`endif
    step(1, 1, 1, 1, 12'h0BB, 1);
    chk_out("clear_cap", 1'b0, '0, '0, '0, '0);
`ifdef LOGGER_HIGH_WATER_EN
    chk("high_water_clr", 32'(high_water), 32'd0);
`endif
    step(0, 0, 1, 1, 12'h0CC, 1);
    step(0, 0, 1, 0, 12'h0DD, 1);
    chk_out("en_low", 1'b0, '0, '0, '0, '0);
    // Sticky flag must have been cleared by clear (overflow at clear edge ignored).
    step(0, 1, 1, 0, 12'h0EE, 0);
    chk_out("after_clear", 1'b1, 13'h00EE, 4'd1, 16'd1, 16'd0);

    // Asynchronous reset mid-operation drops everything immediately.
    step(0, 1, 1, 0, 12'h0EF, 0);
    @(negedge clk);
    en_in = 0; pulse_in = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 12'h000, 0);
    chk_out("rst_release", 1'b0, '0, '0, '0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
